// File: rtl/piso_stream_nbit_pkg.sv
// Shared definitions for the streaming PISO: shifter state encoding and
// the bit-counter width helper.
package piso_stream_nbit_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // Smallest width able to count 0..n-1, never below one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-word holding register with a full flag. A load and a take on the
// same edge leave the buffer full with the newly loaded word.
module piso_hold_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_in,
    input  logic         load_in,
    input  logic         take_in,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out,
    output logic         full_out
);

    logic [N-1:0] data_q, data_d;
    logic         full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (clr_in) begin
            data_d = '0;
            full_d = 1'b0;
        end else if (load_in) begin
            data_d = data_in;
            full_d = 1'b1;
        end else if (take_in) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_out = data_q;
    assign full_out = full_q;

endmodule

// File: rtl/piso_stream_nbit.sv
// Parallel-in/serial-out shifter with valid/ready word loading, selectable
// bit order and a one-word holding buffer for gap-free streaming.
module piso_stream_nbit
    import piso_stream_nbit_pkg::*;
#(
    parameter int   N          = 4,
    parameter bit   LSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset_ah_in,
    input  logic         clr_in,
    input  logic         ld_valid_in,
    output logic         ld_ready_out,
    input  logic [N-1:0] d_in,
    input  logic         shift_en_in,
    output logic         q_out,
    output logic         q_valid_out,
    output logic         last_out,
    output logic         busy_out
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  hold_data;
    logic          hold_full;
    logic          hold_load;
    logic          hold_take;

    logic          act;
    logic          advance;
    logic          word_done;
    logic          accept;
    logic          direct_load;

    assign act       = (state_q == ST_ACTIVE);
    assign advance   = act && shift_en_in;
    assign word_done = advance && (cnt_q == CNT_LAST);

    // Ready depends only on the hold flag, so accept never loops back into ready.
    assign accept      = ld_valid_in && !hold_full && !clr_in;
    assign direct_load = accept && (!act || word_done);
    assign hold_load   = accept && !direct_load;
    assign hold_take   = word_done && hold_full && !clr_in;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (clr_in) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else if (direct_load) begin
            state_d = ST_ACTIVE;
            sreg_d  = d_in;
            cnt_d   = '0;
        end else if (word_done) begin
            cnt_d = '0;
            if (hold_full) begin
                sreg_d = hold_data;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (advance) begin
            cnt_d = cnt_q + CW'(1);
            if (LSB_FIRST) begin
                sreg_d = sreg_q >> 1;
            end else begin
                sreg_d = sreg_q << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_hold_buf #(
        .N(N)
    ) u_hold (
        .clk      (clk),
        .rst      (reset_ah_in),
        .clr_in   (clr_in),
        .load_in  (hold_load),
        .take_in  (hold_take),
        .data_in  (d_in),
        .data_out (hold_data),
        .full_out (hold_full)
    );

    assign ld_ready_out = !hold_full;
    assign q_valid_out  = act;
    assign last_out     = act && (cnt_q == CNT_LAST);
    assign busy_out     = act || hold_full;
    assign q_out        = act ? (LSB_FIRST ? sreg_q[0] : sreg_q[N-1]) : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_stream_nbit.sv
// Bench for piso_stream_nbit: an MSB-first and an LSB-first instance share
// stimulus and are compared against a word-queue reference model.
module tb_piso_stream_nbit;

    localparam int N = 4;
    localparam logic [9:0] IDLE_VEC = 10'b00001_01001;

    logic         clk = 1'b0;
    logic         reset_ah_in;
    logic         clr_in;
    logic         ld_valid_in;
    logic         shift_en_in;
    logic [N-1:0] d_in;

    logic m_ready, m_q, m_qv, m_last, m_busy;
    logic l_ready, l_q, l_qv, l_last, l_busy;

    int checks = 0;
    int fails  = 0;

    // Reference model: words accepted but not yet fully consumed, plus the
    // index of the bit currently presented from the front word.
    logic [N-1:0] mq[$];
    int           pos;

    always #5 clk = ~clk;

    piso_stream_nbit #(.N(N), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_msb (
        .clk(clk), .reset_ah_in(reset_ah_in), .clr_in(clr_in),
        .ld_valid_in(ld_valid_in), .ld_ready_out(m_ready), .d_in(d_in),
        .shift_en_in(shift_en_in), .q_out(m_q), .q_valid_out(m_qv),
        .last_out(m_last), .busy_out(m_busy)
    );

    piso_stream_nbit #(.N(N), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_lsb (
        .clk(clk), .reset_ah_in(reset_ah_in), .clr_in(clr_in),
        .ld_valid_in(ld_valid_in), .ld_ready_out(l_ready), .d_in(d_in),
        .shift_en_in(shift_en_in), .q_out(l_q), .q_valid_out(l_qv),
        .last_out(l_last), .busy_out(l_busy)
    );

    function automatic logic [9:0] obs_vec();
        return {m_qv, m_q, m_last, m_busy, m_ready, l_qv, l_q, l_last, l_busy, l_ready};
    endfunction

    function automatic logic [9:0] exp_vec();
        logic v, bm, bl, lst, rdy;
        v   = (mq.size() > 0);
        bm  = 1'b0;
        bl  = 1'b1;
        lst = 1'b0;
        if (v) begin
            bm  = mq[0][N-1-pos];
            bl  = mq[0][pos];
            lst = (pos == N - 1);
        end
        rdy = (mq.size() < 2);
        return {v, bm, lst, v, rdy, v, bl, lst, v, rdy};
    endfunction

    task automatic model_clear();
        mq.delete();
        pos = 0;
    endtask

    task automatic model_step();
        bit rdy;
        if (reset_ah_in || clr_in) begin
            model_clear();
        end else begin
            rdy = (mq.size() < 2);
            if (mq.size() > 0 && shift_en_in) begin
                if (pos == N - 1) begin
                    void'(mq.pop_front());
                    pos = 0;
                end else begin
                    pos = pos + 1;
                end
            end
            if (ld_valid_in && rdy) mq.push_back(d_in);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_ah_in = 1'b1;
        clr_in = 1'b0; ld_valid_in = 1'b0; shift_en_in = 1'b0; d_in = '0;
        repeat (2) @(negedge clk);
        model_clear();
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            fails++;
            $display("[TB] FAIL reset_init: got %b want %b", obs_vec(), IDLE_VEC);
        end
        reset_ah_in = 1'b0;
        ld_valid_in = 1'b1; d_in = 4'b1011;
        step();
        ld_valid_in = 1'b0; shift_en_in = 1'b1;
        step();
        step();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("[TB] FAIL reset_midword_pre: got %b want %b", obs_vec(), exp_vec());
        end
        #2 reset_ah_in = 1'b1;
        #1;
        model_clear();
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            fails++;
            $display("[TB] FAIL reset_async: got %b want %b", obs_vec(), IDLE_VEC);
        end
        @(negedge clk);
        reset_ah_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec() !== IDLE_VEC) begin
                fails++;
                $display("[TB] FAIL reset_no_more_bits cyc %0d: got %b want %b", i, obs_vec(), IDLE_VEC);
            end
            step();
        end
        shift_en_in = 1'b0;
    endtask

    task automatic test_single_word();
        logic [3:0] bits;
        bits = 4'b1011;
        ld_valid_in = 1'b1; d_in = bits; shift_en_in = 1'b1;
        step();
        ld_valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL single_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            checks++;
            if (i < 4) begin
                if ({m_qv, m_q, m_last} !== {1'b1, bits[3-i], (i == 3)}) begin
                    fails++;
                    $display("[TB] FAIL single_bits cyc %0d: got %b want %b", i, {m_qv, m_q, m_last}, {1'b1, bits[3-i], (i == 3)});
                end
            end else if ({m_qv, m_q, m_last} !== 3'b000) begin
                fails++;
                $display("[TB] FAIL single_idle cyc %0d: got %b want 000", i, {m_qv, m_q, m_last});
            end
            step();
        end
        shift_en_in = 1'b0;
    endtask

    task automatic test_lsb_stall();
        logic [5:0] pat;
        logic [5:0] want;
        pat  = 6'b100111;
        want = 6'b100011;
        ld_valid_in = 1'b1; d_in = 4'b1101; shift_en_in = 1'b0;
        step();
        ld_valid_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            shift_en_in = pat[5-i];
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL lsb_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            checks++;
            if ({l_qv, l_q} !== {1'b1, want[5-i]}) begin
                fails++;
                $display("[TB] FAIL lsb_bits cyc %0d: got %b want %b", i, {l_qv, l_q}, {1'b1, want[5-i]});
            end
            step();
        end
        shift_en_in = 1'b0;
        checks++;
        if ({l_qv, l_q, l_busy} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL lsb_idle: got %b want 010", {l_qv, l_q, l_busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream;
        int nbits;
        int valid_run;
        stream = '0; nbits = 0; valid_run = 0;
        shift_en_in = 1'b1; ld_valid_in = 1'b1; d_in = 4'b1011;
        step();
        for (int i = 0; i < 10; i++) begin
            ld_valid_in = (i == 0);
            d_in = 4'b1101;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL b2b_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (m_qv) begin
                stream = {stream[6:0], m_q};
                nbits++;
                if (i < 8) valid_run++;
            end
            step();
        end
        ld_valid_in = 1'b0; shift_en_in = 1'b0;
        checks++;
        if (stream !== 8'b10111101 || nbits != 8 || valid_run != 8) begin
            fails++;
            $display("[TB] FAIL b2b_stream: got %b (%0d bits, run %0d) want 10111101 (8 bits, run 8)", stream, nbits, valid_run);
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] stream;
        int  nbits;
        bit  accepted;
        bit  acc_now;
        stream = '0; nbits = 0; accepted = 1'b0;
        shift_en_in = 1'b0; ld_valid_in = 1'b1; d_in = 4'b1011;
        step();
        d_in = 4'b1101;
        step();
        d_in = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec() !== exp_vec() || m_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_full cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            step();
        end
        shift_en_in = 1'b1;
        for (int i = 0; i < 30 && !(accepted && mq.size() == 0); i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL bp_model cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            if (m_qv) begin
                stream = {stream[10:0], m_q};
                nbits++;
            end
            acc_now = ld_valid_in && (mq.size() < 2);
            step();
            if (acc_now) begin
                ld_valid_in = 1'b0;
                accepted = 1'b1;
            end
        end
        shift_en_in = 1'b0; ld_valid_in = 1'b0;
        checks++;
        if (!accepted || stream !== 12'b1011_1101_0110 || nbits != 12) begin
            fails++;
            $display("[TB] FAIL bp_stream: accepted %0d got %b (%0d bits) want 101111010110 (12 bits)", accepted, stream, nbits);
        end
    endtask

    task automatic test_clear();
        shift_en_in = 1'b1; ld_valid_in = 1'b1; d_in = 4'b1011;
        step();
        ld_valid_in = 1'b0;
        step();
        clr_in = 1'b1; ld_valid_in = 1'b1; d_in = 4'b1111;
        step();
        clr_in = 1'b0; ld_valid_in = 1'b0;
        checks++;
        if (obs_vec() !== IDLE_VEC || obs_vec() !== exp_vec()) begin
            fails++;
            $display("[TB] FAIL clear_idle: got %b want %b", obs_vec(), IDLE_VEC);
        end
        step();
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            fails++;
            $display("[TB] FAIL clear_load_dropped: got %b want %b", obs_vec(), IDLE_VEC);
        end
        shift_en_in = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL random cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
            ld_valid_in = 1'($urandom_range(0, 1));
            d_in        = N'($urandom);
            shift_en_in = ($urandom_range(0, 3) != 0);
            clr_in      = ($urandom_range(0, 31) == 0);
            step();
        end
        clr_in = 1'b0; ld_valid_in = 1'b0; shift_en_in = 1'b1;
        repeat (10) step();
        checks++;
        if (obs_vec() !== IDLE_VEC) begin
            fails++;
            $display("[TB] FAIL random_drain: got %b want %b", obs_vec(), IDLE_VEC);
        end
        shift_en_in = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_word();
        test_lsb_stall();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
